// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, one-outstanding imem requests,
// a 2-entry {word, pc} queue, and redirect/flush driven by Control's PCSel.
`timescale 1ns/1ps

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    output logic        Inst,
    output logic [2:0]  func3,
    output logic [4:0]  Opcode_m,

    input  logic        PCSel,
    input  logic [31:0] alu_target
);

    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic        outstanding;
    logic        kill;
    logic [1:0]  count;
    logic [1:0]  count_next;

    logic [31:0] hd_word, hd_pc;
    logic [31:0] tl_word, tl_pc;

    logic        consume;
    logic        redirect;
    logic        grant;
    logic        resp;
    logic        push;
    logic        hd_load;
    logic        hd_shift;
    logic        tl_load;
    logic [2:0]  occupancy;

    assign inst_valid = (count != 2'd0);
    assign consume    = inst_valid & inst_ready;
    assign redirect   = consume & PCSel;
    assign resp       = imem_rvalid & outstanding;
    assign push       = resp & ~kill & ~redirect;

    // Slots the queue will hold after this edge, counting a live response;
    // a request is only issued when its response is guaranteed a slot.
    assign occupancy = {1'b0, count} - {2'b00, consume} + {2'b00, imem_rvalid & ~kill};

    assign imem_req  = ~rst & ~redirect & (~outstanding | imem_rvalid) & (occupancy < 3'd2);
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        hd_load    = 1'b0;
        hd_shift   = 1'b0;
        tl_load    = 1'b0;
        if (redirect) begin
            count_next = 2'd0;
        end else begin
            count_next = count + {1'b0, push} - {1'b0, consume};
            hd_shift   = consume & (count == 2'd2);
            hd_load    = push & ((count == 2'd0) | ((count == 2'd1) & consume));
            tl_load    = push & (((count == 2'd1) & ~consume) | ((count == 2'd2) & consume));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
            kill        <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc <= alu_target & 32'hFFFF_FFFC;
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (grant) begin
                req_pc <= fetch_pc;
            end

            if (grant) begin
                outstanding <= 1'b1;
            end else if (resp) begin
                outstanding <= 1'b0;
            end

            // A flushed request whose data is still in flight must be swallowed.
            if (redirect && outstanding && !imem_rvalid) begin
                kill <= 1'b1;
            end else if (resp && kill) begin
                kill <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 2'd0;
            hd_word <= 32'd0;
            hd_pc   <= 32'd0;
        end else begin
            count <= count_next;
            if (hd_load) begin
                hd_word <= imem_rdata;
                hd_pc   <= req_pc;
            end else if (hd_shift) begin
                hd_word <= tl_word;
                hd_pc   <= tl_pc;
            end
        end
    end

    // NOTE: the tail entry carries no reset; it is only read after a push
    // has written it, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (tl_load) begin
            tl_word <= imem_rdata;
            tl_pc   <= req_pc;
        end
    end

    assign inst     = hd_word;
    assign inst_pc  = hd_pc;
    assign pc_plus4 = hd_pc + 32'd4;
    assign Inst     = hd_word[30];
    assign func3    = hd_word[14:12];
    assign Opcode_m = hd_word[6:2];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for streaming, backpressure and
// same-cycle redirect, plus hand sequences for killed responses, delays, reset.
`timescale 1ns/1ps

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic        Inst;
    logic [2:0]  func3;
    logic [4:0]  Opcode_m;
    logic        PCSel = 1'b0;
    logic [31:0] alu_target = 32'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .pc_plus4   (pc_plus4),
        .Inst       (Inst),
        .func3      (func3),
        .Opcode_m   (Opcode_m),
        .PCSel      (PCSel),
        .alu_target (alu_target)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: grant after gnt_delay waiting cycles, data rlat cycles later.
    int unsigned gnt_delay = 0;
    int unsigned rlat      = 1;
    int unsigned wait_cnt  = 0;
    int unsigned pend_cnt  = 0;
    logic        pend      = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    bit          keep_pend = 1'b0;

    assign imem_gnt    = imem_req && (wait_cnt >= gnt_delay);
    assign imem_rvalid = pend && (pend_cnt == 0);
    assign imem_rdata  = mem_word(pend_addr);

    always @(posedge clk) begin
        if (rst && !keep_pend) begin
            pend     <= 1'b0;
            wait_cnt <= 0;
        end else begin
            if (imem_req && imem_gnt) begin
                pend      <= 1'b1;
                pend_cnt  <= rlat - 1;
                pend_addr <= imem_addr;
            end else if (pend && pend_cnt == 0) begin
                pend <= 1'b0;
            end else if (pend) begin
                pend_cnt <= pend_cnt - 1;
            end
            wait_cnt <= (imem_req && !imem_gnt) ? wait_cnt + 1 : 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Address must not move while a request waits for its grant.
    bit          chk_stable = 1'b0;
    bit          hold       = 1'b0;
    logic [31:0] hold_addr  = 32'd0;
    always @(negedge clk) begin
        if (chk_stable && hold && imem_req)
            check("addr_stable", imem_addr, hold_addr);
        hold      = imem_req && !imem_gnt;
        hold_addr = imem_addr;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input string tag, input bit v, input logic [31:0] pc,
                                input bit req, input logic [31:0] addr);
        logic [31:0] w;
        w = mem_word(pc);
        check({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, v});
        if (v) begin
            check({tag, " inst_pc"}, inst_pc, pc);
            check({tag, " inst"}, inst, w);
            check({tag, " pc_plus4"}, pc_plus4, pc + 32'd4);
            check({tag, " Inst"}, {31'd0, Inst}, {31'd0, w[30]});
            check({tag, " func3"}, {29'd0, func3}, {29'd0, w[14:12]});
            check({tag, " Opcode_m"}, {27'd0, Opcode_m}, {27'd0, w[6:2]});
        end
        check({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, req});
        if (req)
            check({tag, " imem_addr"}, imem_addr, addr);
    endtask

    // Leaves the bench at C0: first cycle after reset release.
    task automatic do_reset();
        rst        = 1'b1;
        inst_ready = 1'b0;
        PCSel      = 1'b0;
        alu_target = 32'd0;
        rlat       = 1;
        gnt_delay  = 0;
        next_cycle();
        check("rst inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst imem_req", {31'd0, imem_req}, 32'd0);
        check("rst inst", inst, 32'd0);
        check("rst inst_pc", inst_pc, 32'd0);
        next_cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        bit          fresh;
        bit          ready;
        bit          pcsel;
        logic [31:0] target;
        bit          v;
        logic [31:0] pc;
        bit          req;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit fresh, input bit ready, input bit pcsel,
                                input logic [31:0] target, input bit v,
                                input logic [31:0] pc, input bit req, input logic [31:0] addr);
        vec_t e;
        e.fresh = fresh; e.ready = ready; e.pcsel = pcsel; e.target = target;
        e.v = v; e.pc = pc; e.req = req; e.addr = addr;
        tbl.push_back(e);
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_pc;
        int got;

        // Zero-wait streaming: valid in C2, then one PC per cycle.
        add(1, 1, 0, 0, 0, 0,  1, 0);
        add(0, 1, 0, 0, 0, 0,  1, 4);
        add(0, 1, 0, 0, 1, 0,  1, 8);
        add(0, 1, 0, 0, 1, 4,  1, 12);
        add(0, 1, 0, 0, 1, 8,  1, 16);
        add(0, 1, 0, 0, 1, 12, 1, 20);
        // Backpressure for 10 cycles, queue fills to 2, then drains in order.
        add(1, 0, 0, 0, 0, 0,  1, 0);
        add(0, 0, 0, 0, 0, 0,  1, 4);
        for (int i = 2; i < 10; i++)
            add(0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0,  1, 8);
        add(0, 1, 0, 0, 1, 4,  1, 12);
        add(0, 1, 0, 0, 1, 8,  1, 16);
        add(0, 1, 0, 0, 1, 12, 1, 20);
        // Redirect at pc 8 while the word for 12 arrives the same cycle.
        add(1, 1, 0, 0, 0, 0,  1, 0);
        add(0, 1, 0, 0, 0, 0,  1, 4);
        add(0, 1, 0, 0, 1, 0,  1, 8);
        add(0, 1, 0, 0, 1, 4,  1, 12);
        add(0, 1, 1, 32'h0000_0202, 1, 8, 0, 0);
        add(0, 1, 0, 0, 0, 0,  1, 32'h200);
        add(0, 1, 0, 0, 0, 0,  1, 32'h204);
        add(0, 1, 0, 0, 1, 32'h200, 1, 32'h208);
        add(0, 1, 0, 0, 1, 32'h204, 1, 32'h20C);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].fresh)
                do_reset();
            inst_ready = tbl[i].ready;
            PCSel      = tbl[i].pcsel;
            alu_target = tbl[i].target;
            #1;
            expect_cycle($sformatf("vec%0d", i), tbl[i].v, tbl[i].pc, tbl[i].req, tbl[i].addr);
            next_cycle();
        end
        PCSel = 1'b0;

        // Redirect with the response for 12 still in flight: it is killed.
        do_reset();
        inst_ready = 1'b1;
        rlat       = 2;
        #1; expect_cycle("kill C0", 0, 0, 1, 0);             next_cycle();
        #1; expect_cycle("kill C1", 0, 0, 0, 0);             next_cycle();
        #1; expect_cycle("kill C2", 0, 0, 1, 4);             next_cycle();
        #1; expect_cycle("kill C3", 1, 0, 0, 0);             next_cycle();
        #1; expect_cycle("kill C4", 0, 0, 1, 8);             next_cycle();
        #1; expect_cycle("kill C5", 1, 4, 0, 0);             next_cycle();
        #1; expect_cycle("kill C6", 0, 0, 1, 12);            next_cycle();
        PCSel      = 1'b1;
        alu_target = 32'h0000_0103;
        rlat       = 1;
        #1; expect_cycle("kill R", 1, 8, 0, 0);              next_cycle();
        PCSel      = 1'b0;
        #1; expect_cycle("kill R+1", 0, 0, 1, 32'h100);      next_cycle();
        #1; expect_cycle("kill R+2", 0, 0, 1, 32'h104);      next_cycle();
        #1; expect_cycle("kill R+3", 1, 32'h100, 1, 32'h108); next_cycle();
        #1; expect_cycle("kill R+4", 1, 32'h104, 1, 32'h10C); next_cycle();

        // Grant delayed 3 cycles; PCSel held high whenever nothing is valid.
        do_reset();
        inst_ready = 1'b1;
        gnt_delay  = 3;
        alu_target = 32'h0000_0300;
        chk_stable = 1'b1;
        exp_pc     = 0;
        got        = 0;
        for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
            PCSel = !inst_valid;
            #1;
            if (inst_valid) begin
                check("delay inst_pc", inst_pc, exp_pc);
                check("delay inst", inst, mem_word(exp_pc));
                exp_pc += 4;
                got++;
            end
            next_cycle();
        end
        check("delay count", got, 5);
        chk_stable = 1'b0;
        PCSel      = 1'b0;
        gnt_delay  = 0;

        // Reset with a request outstanding; its late rvalid lands after release.
        do_reset();
        inst_ready = 1'b1;
        rlat       = 2;
        #1; expect_cycle("rst C0", 0, 0, 1, 0);              next_cycle();
        #1; expect_cycle("rst C1", 0, 0, 0, 0);              next_cycle();
        #1; expect_cycle("rst C2", 0, 0, 1, 4);              next_cycle();
        #1; expect_cycle("rst C3", 1, 0, 0, 0);
        keep_pend = 1'b1;
        rst       = 1'b1;
        #1; check("rst mid imem_req", {31'd0, imem_req}, 32'd0);
        next_cycle();
        rst  = 1'b0;
        rlat = 1;
        #1;
        check("rst stray present", {31'd0, imem_rvalid}, 32'd1);
        check("rst after inst_pc", inst_pc, 32'd0);
        expect_cycle("rst C0'", 0, 0, 1, 0);
        next_cycle();
        keep_pend = 1'b0;
        #1; expect_cycle("rst C1'", 0, 0, 1, 4);             next_cycle();
        #1; expect_cycle("rst C2'", 1, 0, 1, 8);             next_cycle();
        #1; expect_cycle("rst C3'", 1, 4, 1, 12);            next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
